right_shift_deser_ctrl: RTL and testbench
=========================================

# right_shift_deser_ctrl

Sequencing controller for a right-shifting serial-to-parallel register. It accepts serial bits over a valid/ready handshake and counts them into a DEPTH-bit word. The word is presented on a valid/ready output port, and an explicit flush zero-pads a partial word. It sits between a serial bit source and any word-wide consumer.

## Interface
- DEPTH, 8, word width in bits; must be ≥ 2
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in  input  1  serial data bit
- in_valid  input  1  `in` carries a bit this cycle
- in_ready  output  1  controller accepts `in` this cycle
- flush  input  1  request zero-padding of the current partial word
- out  output  DEPTH  shift register contents
- out_valid  output  1  `out` holds a complete word
- out_ready  input  1  consumer takes the word this cycle
- bit_count  output  $clog2(DEPTH)+1  number of bits currently held, 0..DEPTH

## Operation
- Storage is one DEPTH-bit right shift register.
  - A shift loads the new bit at out[DEPTH-1] and moves every bit down one place.
  - The first bit of a word ends at out[0]; the last bit ends at out[DEPTH-1].
- The FSM has three states: FILL, PAD and FULL. Reset enters FILL.
- Accept occurs when in_valid && in_ready.
- Consume occurs when out_valid && out_ready.
- in_ready = (state==FILL) || (state==FULL && out_ready). It is combinational from state and out_ready.
- out_valid = (state==FULL). It is decoded from the registered state.
- FILL:
  - On accept: shift in `in` and increment bit_count.
  - If bit_count was DEPTH-1 before the accept, go to FULL.
  - flush with bit_count>0 and no completing accept: go to PAD. If an accept occurs in the same cycle, the bit is shifted in first.
  - flush with bit_count==0: ignored.
- PAD:
  - in_ready=0.
  - Shift in one 0 per cycle and increment bit_count.
  - Go to FULL on the cycle bit_count reaches DEPTH.
  - flush is ignored.
- FULL:
  - out and bit_count (=DEPTH) are held stable until consume.
  - On consume without accept: clear the register to 0, set bit_count=0, go to FILL.
  - On consume with accept: load the register with `in` at out[DEPTH-1] and zeros elsewhere, set bit_count=1, go to FILL.
  - flush is ignored.
- Reset, taking priority over everything:
  - register = 0, bit_count = 0, state = FILL.
  - Inputs are ignored in the reset cycle.
  - A word in progress or held in FULL is discarded; no out_valid pulse is produced for it.

## Timing
- Reset values:
  - During reset and after the reset edge: out=0, out_valid=0, bit_count=0.
  - in_ready=1 after the reset edge.
- All state changes occur on the rising clk edge. There is no asynchronous path.
- Latency: out_valid rises the cycle after the edge that accepts the DEPTH-th bit.
- Throughput:
  - With in_valid and out_ready held high, a word is completed every DEPTH cycles with zero bubbles.
  - out_valid is high for 1 cycle in every DEPTH.
- Flush: with k bits held (0<k<DEPTH), out_valid rises DEPTH-k cycles after the edge that registers flush.
- Backpressure: in FULL with out_ready=0, in_ready=0. The `in` value is ignored and no bit is lost.
- Idle cycles: in_valid=0 gaps in FILL leave the register and count unchanged.

## Test plan
- Reset:
  - Stimulus: hold reset 2 cycles.
  - Required: out=8'b0, out_valid=0, bit_count=0; in_ready=1 after release.
- Single word with backpressure:
  - Stimulus: feed bits 1,1,0,1,0,1,1,0 contiguously with out_ready=0.
  - Required: after the 8th edge, out=8'b01101011, bit_count=8, out_valid=1, in_ready=0.
  - Values stay held for 3 stall cycles.
  - Raising out_ready gives out=0 and bit_count=0 on the next edge.
- Back-to-back words:
  - Stimulus: out_ready=1, stream 16 bits forming 0xA5 then 0x3C (LSB first).
  - Required: out_valid pulses exactly twice, 8 cycles apart, with out=8'hA5 then 8'h3C.
  - in_ready never drops.
  - The first bit of the second word appears at out[7] with bit_count=1.
- Flush:
  - Stimulus: feed 1,0,1, then pulse flush for 1 cycle.
  - Required: in_ready=0 for 5 cycles, then out=8'b00000101, bit_count=8, out_valid=1.
  - flush with bit_count=0 causes no state change.
- Reset mid-word:
  - Stimulus: feed 4 bits, assert reset for 1 cycle, then feed bit 1.
  - Required: out=0 and bit_count=0 after reset; then out=8'b10000000, bit_count=1, and no out_valid.
- Gapped input:
  - Stimulus: feed 1,1,0,1,0,1,1,0 with 2 idle in_valid=0 cycles between bits.
  - Required: final out=8'b01101011, identical to the contiguous case; out_valid rises only after the 8th accept.

Source files
------------

// File: rtl/right_shift_deser_ctrl_if.sv
// Serial-in / word-out handshake bundle for the right-shift deserializer.
// Master is the bit source plus word consumer; slave is the controller.
interface right_shift_deser_ctrl_if #(
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             in;
   logic             in_valid;
   logic             in_ready;
   logic             flush;
   logic [DEPTH-1:0] out;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    bit_count;

   modport master (
      output in, in_valid, flush, out_ready,
      input  in_ready, out, out_valid, bit_count
   );

   modport slave (
      input  in, in_valid, flush, out_ready,
      output in_ready, out, out_valid, bit_count
   );
endinterface

// File: rtl/right_shift_deser_ctrl.sv
// Right-shift serial-to-parallel controller: word valid the cycle after the DEPTH-th accept
// (or DEPTH-k cycles after a flush); while a held word is stalled, in_ready drops so no bit is lost.
module right_shift_deser_ctrl #(
   parameter int DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   right_shift_deser_ctrl_if.slave       bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      PAD  = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [DEPTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             in_ready;
   logic             accept;
   logic             consume;
   logic             last_bit;

   assign in_ready = (state_q == FILL) || ((state_q == FULL) && bus.out_ready);
   assign accept   = bus.in_valid && in_ready;
   assign consume  = (state_q == FULL) && bus.out_ready;
   assign last_bit = (cnt_q == CW'(DEPTH - 1));

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         FILL: begin
            if (accept) begin
               shreg_d = {bus.in, shreg_q[DEPTH-1:1]};
               cnt_d   = cnt_q + CW'(1);
               if (last_bit) begin
                  state_d = FULL;
               end else if (bus.flush) begin
                  state_d = PAD;
               end
            end else if (bus.flush && (cnt_q != '0)) begin
               state_d = PAD;
            end
         end
         PAD: begin
            shreg_d = {1'b0, shreg_q[DEPTH-1:1]};
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
               state_d = FULL;
            end
         end
         FULL: begin
            // A consume frees the slot, so a bit offered in the same cycle starts the next word.
            if (consume) begin
               state_d = FILL;
               if (accept) begin
                  shreg_d = {bus.in, {(DEPTH-1){1'b0}}};
                  cnt_d   = CW'(1);
               end else begin
                  shreg_d = '0;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = FILL;
            shreg_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FILL;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out       = shreg_q;
   assign bus.out_valid = (state_q == FULL);
   assign bus.bit_count = cnt_q;
endmodule

// File: tb/tb_right_shift_deser_ctrl.sv
// Directed bench for right_shift_deser_ctrl (DEPTH=8): reset, backpressure, streaming,
// flush padding, mid-word reset and gapped input, with hand-computed expectations.
module tb_right_shift_deser_ctrl;
   localparam int DEPTH = 8;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   right_shift_deser_ctrl_if #(.DEPTH(DEPTH)) bus ();

   right_shift_deser_ctrl #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_word(input string tag, input logic [7:0] o, input int cnt, input logic ov);
      check({tag, ".out"}, 32'(bus.out), 32'(o));
      check({tag, ".bit_count"}, 32'(bus.bit_count), 32'(cnt));
      check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
   endtask

   logic [7:0] w_a;
   logic [7:0] w_b;
   logic [7:0] w_c;
   logic [7:0] bit_pat;
   int         pulses;
   int         pulse_at [2];

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      reset         = 1'b1;
      bus.in        = 1'b0;
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      w_a           = 8'b01101011;
      w_b           = 8'hA5;
      w_c           = 8'h3C;
      pulses        = 0;
      pulse_at[0]   = -1;
      pulse_at[1]   = -1;

      // Reset held for two cycles
      #1;
      step();
      step();
      check_word("rst_during", 8'h00, 0, 1'b0);
      reset = 1'b0;
      step();
      check_word("rst_after", 8'h00, 0, 1'b0);
      check("rst_after.in_ready", 32'(bus.in_ready), 32'd1);

      // Single word under backpressure
      for (int i = 0; i < 8; i++) begin
         bus.in       = w_a[i];
         bus.in_valid = 1'b1;
         step();
         if (i == 6) check("bp.no_early_valid", 32'(bus.out_valid), 32'd0);
      end
      check_word("bp.full", w_a, 8, 1'b1);
      check("bp.in_ready", 32'(bus.in_ready), 32'd0);
      bus.in = 1'b1;
      for (int s = 0; s < 3; s++) begin
         step();
         check_word($sformatf("bp.stall%0d", s), w_a, 8, 1'b1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      check("bp.rdy_on_consume", 32'(bus.in_ready), 32'd1);
      step();
      check_word("bp.consumed", 8'h00, 0, 1'b0);

      // Back-to-back words 0xA5 then 0x3C with out_ready held high
      for (int i = 0; i < 16; i++) begin
         bus.in       = (i < 8) ? w_b[i] : w_c[i-8];
         bus.in_valid = 1'b1;
         #1;
         check($sformatf("b2b.in_ready%0d", i), 32'(bus.in_ready), 32'd1);
         step();
         if (bus.out_valid) begin
            if (pulses < 2) begin
               pulse_at[pulses] = i;
               check($sformatf("b2b.word%0d", pulses), 32'(bus.out),
                     (pulses == 0) ? 32'hA5 : 32'h3C);
            end
            pulses++;
         end
         if (i == 8) begin
            check("b2b.first_bit_msb", 32'(bus.out[7]), 32'(w_c[0]));
            check("b2b.first_bit_cnt", 32'(bus.bit_count), 32'd1);
         end
      end
      bus.in_valid = 1'b0;
      step();
      check_word("b2b.drained", 8'h00, 0, 1'b0);
      check("b2b.pulses", 32'(pulses), 32'd2);
      check("b2b.first_at", 32'(pulse_at[0]), 32'd7);
      check("b2b.spacing", 32'(pulse_at[1] - pulse_at[0]), 32'd8);

      // Flush after three bits: five PAD cycles then a padded word
      bus.out_ready = 1'b0;
      bit_pat       = 8'b00000101;
      for (int i = 0; i < 3; i++) begin
         bus.in       = bit_pat[i];
         bus.in_valid = 1'b1;
         step();
      end
      bus.in_valid = 1'b0;
      bus.flush    = 1'b1;
      step();
      bus.flush = 1'b0;
      for (int p = 0; p < 5; p++) begin
         check($sformatf("fl.pad_rdy%0d", p), 32'(bus.in_ready), 32'd0);
         check($sformatf("fl.pad_vld%0d", p), 32'(bus.out_valid), 32'd0);
         step();
      end
      check_word("fl.full", 8'b00000101, 8, 1'b1);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check_word("fl.consumed", 8'h00, 0, 1'b0);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      check_word("fl.empty_flush", 8'h00, 0, 1'b0);
      check("fl.empty_rdy", 32'(bus.in_ready), 32'd1);
      step();
      check("fl.empty_rdy2", 32'(bus.in_ready), 32'd1);
      check_word("fl.empty_flush2", 8'h00, 0, 1'b0);

      // Reset in the middle of a word
      for (int i = 0; i < 4; i++) begin
         bus.in       = 1'b1;
         bus.in_valid = 1'b1;
         step();
      end
      check_word("mr.partial", 8'hF0, 4, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.in_valid = 1'b0;
      check_word("mr.cleared", 8'h00, 0, 1'b0);
      bus.in       = 1'b1;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check_word("mr.one_bit", 8'h80, 1, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_word("mr.reset2", 8'h00, 0, 1'b0);

      // Gapped input: two idle cycles between accepts
      for (int i = 0; i < 8; i++) begin
         bus.in       = w_a[i];
         bus.in_valid = 1'b1;
         step();
         bus.in_valid = 1'b0;
         bus.in       = ~w_a[i];
         if (i < 7) begin
            step();
            step();
            check($sformatf("gap.cnt%0d", i), 32'(bus.bit_count), 32'(i + 1));
            check($sformatf("gap.vld%0d", i), 32'(bus.out_valid), 32'd0);
         end
      end
      check_word("gap.full", w_a, 8, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
